arbitro_rr: RTL and testbench

Parametrised successor of the single-input class arbiter. Serves NUM_IN first-word-fall-through input FIFOs (one per class) and routes each popped word by its destination field to one of NUM_OUT output FIFOs. Arbitration mode is selectable at run time: round-robin or strict priority. Backpressure is per output: an input is blocked only when the output its head word targets is almost full, so other inputs keep flowing. Sits between the class FIFOs and the destination FIFOs in the router datapath.

---
 rtl/arbitro_rr_pkg.sv | 26 ++
 rtl/arbitro_rr_if.sv | 28 ++
 rtl/arbitro_rr_arb.sv | 39 +++
 rtl/arbitro_rr.sv | 110 +++++++++++
 tb/tb_arbitro_rr.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_pkg.sv
// Shared word layout, arbitration mode encoding and width helper for the class arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

   // Word layout: [11:10] class, [9:8] destination, [7:0] data
   localparam int CLASS_MSB = 11;
   localparam int CLASS_LSB = 10;
   localparam int DEST_MSB  = 9;
   localparam int DEST_LSB  = 8;
   localparam int DATA_W    = 8;

   typedef enum logic {
      RR     = 1'b0,
      STRICT = 1'b1
   } arb_mode_e;

   // Ceiling log2; returns 0 for values <= 1, callers clamp the width to 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Bundle between the class FIFOs / destination FIFOs and the arbiter.
// Latency: pop combinational, push/data_out/err_dest/active registered.
// Backpressure: per-output almost-full flags; slave = arbiter side, master = FIFO/bench side.
interface arbitro_rr_if #(
   parameter int WORD_SIZE = 12,
   parameter int NUM_IN    = 4,
   parameter int NUM_OUT   = 4
);
   logic                          arb_mode;           // 0 round-robin, 1 strict priority
   logic [NUM_IN*WORD_SIZE-1:0]   data_in;            // FWFT head words, input i at [i*WORD_SIZE +: WORD_SIZE]
   logic [NUM_IN-1:0]             fifo_empty;         // per input FIFO
   logic [NUM_OUT-1:0]            fifos_almost_full;  // per output FIFO
   logic [NUM_IN-1:0]             pop;                // one-hot pop to input FIFOs
   logic [NUM_OUT-1:0]            push;               // one-hot push to output FIFOs
   logic [WORD_SIZE-1:0]          data_out;           // word accompanying push
   logic                          err_dest;           // out-of-range destination discarded
   logic                          active;             // push or discard this cycle

   modport slave (
      input  arb_mode, data_in, fifo_empty, fifos_almost_full,
      output pop, push, data_out, err_dest, active
   );

   modport master (
      output arb_mode, data_in, fifo_empty, fifos_almost_full,
      input  pop, push, data_out, err_dest, active
   );
endinterface

// File: rtl/arbitro_rr_arb.sv
// Combinational one-of-N grant: strict (lowest index) or round-robin after ptr_i.
// Latency: zero, purely combinational; the pointer register lives in the parent.
// Backpressure: callers mask blocked requesters out of req_i before arbitration.
// Ports: req_i requests, mode_i arbitration mode, ptr_i last winner,
//        gnt_o one-hot grant, idx_o binary grant index, vld_o any grant.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  arb_mode_e     mode_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW-1:0] cand;

   // Visit candidates in priority order and keep the first requester found.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         if (mode_i == STRICT) cand = IW'(k - 1);
         else                  cand = IW'((int'(ptr_i) + k) % N);
         if (!vld_o && req_i[cand]) begin
            vld_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/arbitro_rr.sv
// Arbitrates NUM_IN FWFT class FIFOs and routes each popped word to its destination FIFO.
// Latency: pop is combinational; push/data_out one cycle later; one word per cycle.
// Backpressure: an input is held only while its head's destination is almost full.
// Ports: clk, reset (async active-low), bus (slave modport: mode, heads, empties,
//        almost-full in; pop, push, data_out, err_dest, active out).
module arbitro_rr #(
   parameter int WORD_SIZE = 12,
   parameter int NUM_IN    = 4,
   parameter int NUM_OUT   = 4,
   parameter int DEST_LSB  = arb_pkg::DEST_LSB
) (
   input  logic         clk,
   input  logic         reset,
   arbitro_rr_if.slave  bus
);
   import arb_pkg::*;

   localparam int DEST_W = (NUM_OUT > 1) ? clog2(NUM_OUT) : 1;
   localparam int IW     = (NUM_IN > 1) ? clog2(NUM_IN) : 1;

   logic [WORD_SIZE-1:0] head      [NUM_IN];
   logic [DEST_W-1:0]    head_dest [NUM_IN];
   logic [NUM_IN-1:0]    req;
   logic [NUM_IN-1:0]    gnt;
   logic [IW-1:0]        gnt_idx;
   logic                 gnt_vld;
   logic [WORD_SIZE-1:0] sel_word;
   logic [DEST_W-1:0]    sel_dest;
   arb_mode_e            mode;

   logic [NUM_OUT-1:0]   push_q, push_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic                 err_q, err_d;
   logic                 active_q, active_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;

   assign mode = arb_mode_e'(bus.arb_mode);

   // Eligibility looks at the current almost-full flags, so a flag rising this
   // cycle already blocks the grant. Out-of-range destinations never block:
   // those words are drained and reported.
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         head[i]      = bus.data_in[i*WORD_SIZE +: WORD_SIZE];
         head_dest[i] = head[i][DEST_LSB +: DEST_W];
         req[i]       = 1'b0;
         if (!bus.fifo_empty[i]) begin
            if (int'(head_dest[i]) >= NUM_OUT) req[i] = 1'b1;
            else                               req[i] = !bus.fifos_almost_full[head_dest[i]];
         end
      end
   end

   rr_arbiter #(.N(NUM_IN)) u_arb (
      .req_i  (req),
      .mode_i (mode),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (gnt),
      .idx_o  (gnt_idx),
      .vld_o  (gnt_vld)
   );

   assign sel_word = head[gnt_idx];
   assign sel_dest = head_dest[gnt_idx];

   // Pop is held low during reset so the FIFOs never lose a word to a
   // grant that the registers cannot capture.
   assign bus.pop = reset ? gnt : '0;

   always_comb begin
      push_d   = '0;
      data_d   = '0;
      err_d    = 1'b0;
      active_d = 1'b0;
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         active_d = 1'b1;
         rr_ptr_d = gnt_idx;
         if (int'(sel_dest) < NUM_OUT) begin
            push_d[sel_dest] = 1'b1;
            data_d           = sel_word;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Pointer resets to the last input so input 0 wins the first round.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push_q   <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         active_q <= 1'b0;
         rr_ptr_q <= IW'(NUM_IN - 1);
      end else begin
         push_q   <= push_d;
         data_q   <= data_d;
         err_q    <= err_d;
         active_q <= active_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.push     = push_q;
   assign bus.data_out = data_q;
   assign bus.err_dest = err_q;
   assign bus.active   = active_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: directed scenarios plus randomized traffic
// against a queue-based model of the class FIFOs and the grant rules.
// A second instance with three outputs exercises out-of-range destinations.
module tb_arbitro_rr;

   logic clk;
   logic reset;

   arbitro_rr_if #(.WORD_SIZE(12), .NUM_IN(4), .NUM_OUT(4)) a_if ();
   arbitro_rr_if #(.WORD_SIZE(12), .NUM_IN(4), .NUM_OUT(3)) b_if ();

   arbitro_rr #(.WORD_SIZE(12), .NUM_IN(4), .NUM_OUT(4), .DEST_LSB(8)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if.slave)
   );

   arbitro_rr #(.WORD_SIZE(12), .NUM_IN(4), .NUM_OUT(3), .DEST_LSB(8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state: contents of each input FIFO, flags, last winner.
   logic [11:0] q [4][$];
   logic [3:0]  af_v;
   logic        mode_v;
   int          ptr_m;

   // Expected winner from the eligibility and priority rules; -1 when none.
   function automatic int ref_grant();
      bit          elig [4];
      logic [11:0] w;
      for (int i = 0; i < 4; i++) begin
         elig[i] = 1'b0;
         if (q[i].size() != 0) begin
            w       = q[i][0];
            elig[i] = !af_v[w[9:8]];
         end
      end
      if (mode_v) begin
         for (int i = 0; i < 4; i++) if (elig[i]) return i;
      end else begin
         for (int k = 1; k <= 4; k++) if (elig[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         a_if.fifo_empty[i]       = (q[i].size() == 0);
         a_if.data_in[i*12 +: 12] = (q[i].size() != 0) ? q[i][0] : 12'h000;
      end
      a_if.fifos_almost_full = af_v;
      a_if.arb_mode          = mode_v;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) q[i].delete();
      af_v   = 4'b0000;
      mode_v = 1'b0;
      drive();
      b_if.arb_mode          = 1'b0;
      b_if.data_in           = '0;
      b_if.fifo_empty        = 4'b1111;
      b_if.fifos_almost_full = 3'b000;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      ptr_m = 3;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         q[i].push_back({2'(i), 2'b00, 8'hA0 + 8'(i)});
      end
      af_v = 4'b0000; mode_v = 1'b0;
      drive();
      b_if.arb_mode = 1'b0; b_if.data_in = '0; b_if.fifo_empty = 4'b1111; b_if.fifos_almost_full = 3'b000;
      @(posedge clk); #1;
      tests_run++;
      if (a_if.pop !== 4'b0000) begin tests_failed++; $display("FAIL reset_pop: got %b expected 0000", a_if.pop); end
      tests_run++;
      if (a_if.push !== 4'b0000) begin tests_failed++; $display("FAIL reset_push: got %b expected 0000", a_if.push); end
      tests_run++;
      if (a_if.data_out !== 12'h000) begin tests_failed++; $display("FAIL reset_data: got %h expected 000", a_if.data_out); end
      tests_run++;
      if (a_if.err_dest !== 1'b0 || a_if.active !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags: got err=%b active=%b expected 0 0", a_if.err_dest, a_if.active);
      end
      reset = 1'b1; ptr_m = 3;
      #1;
      tests_run++;
      if (a_if.pop !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_pop: got %b expected 0001", a_if.pop); end
   endtask

   task automatic test_round_robin();
      logic [3:0]  seq [5];
      logic [11:0] w;
      int          g;
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
      do_reset();
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < 4; i++) q[i].push_back({2'(i), 2'b00, 8'($urandom_range(0, 255))});
      for (int c = 0; c < 5; c++) begin
         drive(); #1;
         tests_run++;
         if (a_if.pop !== seq[c]) begin tests_failed++; $display("FAIL rr_pop cycle %0d: got %b expected %b", c, a_if.pop, seq[c]); end
         g = ref_grant();
         w = (g >= 0) ? q[g][0] : 12'h000;
         @(posedge clk);
         if (g >= 0) begin void'(q[g].pop_front()); ptr_m = g; end
         #1;
         tests_run++;
         if (a_if.push !== 4'b0001 || a_if.data_out !== w) begin
            tests_failed++; $display("FAIL rr_push cycle %0d: got push=%b data=%h expected 0001 %h", c, a_if.push, a_if.data_out, w);
         end
      end
   endtask

   task automatic test_strict();
      logic [3:0]  exp_pop, exp_push;
      logic [11:0] w;
      int          g;
      do_reset();
      mode_v = 1'b1;
      for (int n = 0; n < 3; n++) q[0].push_back({2'd0, 2'd1, 8'($urandom_range(0, 255))});
      for (int n = 0; n < 2; n++) q[2].push_back({2'd2, 2'd3, 8'($urandom_range(0, 255))});
      for (int c = 0; c < 6; c++) begin
         g       = (q[0].size() != 0) ? 0 : (q[2].size() != 0) ? 2 : -1;
         exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         w       = (g >= 0) ? q[g][0] : 12'h000;
         drive(); #1;
         tests_run++;
         if (a_if.pop !== exp_pop) begin tests_failed++; $display("FAIL strict_pop cycle %0d: got %b expected %b", c, a_if.pop, exp_pop); end
         @(posedge clk);
         if (g >= 0) begin void'(q[g].pop_front()); ptr_m = g; end
         #1;
         exp_push = (g >= 0) ? (4'b0001 << w[9:8]) : 4'b0000;
         tests_run++;
         if (a_if.push !== exp_push || a_if.data_out !== w) begin
            tests_failed++; $display("FAIL strict_push cycle %0d: got %b %h expected %b %h", c, a_if.push, a_if.data_out, exp_push, w);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      q[0].push_back(12'h0AA);
      q[1].push_back(12'h5BB);
      af_v = 4'b0001;
      drive(); #1;
      tests_run++;
      if (a_if.pop !== 4'b0010) begin tests_failed++; $display("FAIL bp_pop: got %b expected 0010", a_if.pop); end
      @(posedge clk); void'(q[1].pop_front()); ptr_m = 1; #1;
      tests_run++;
      if (a_if.push !== 4'b0010 || a_if.data_out !== 12'h5BB) begin
         tests_failed++; $display("FAIL bp_push: got %b %h expected 0010 5bb", a_if.push, a_if.data_out);
      end
      for (int c = 0; c < 2; c++) begin
         drive(); #1;
         tests_run++;
         if (a_if.pop !== 4'b0000) begin tests_failed++; $display("FAIL bp_hold cycle %0d: got %b expected 0000", c, a_if.pop); end
         @(posedge clk); #1;
         tests_run++;
         if (a_if.push !== 4'b0000 || a_if.active !== 1'b0) begin
            tests_failed++; $display("FAIL bp_idle cycle %0d: got push=%b active=%b expected 0000 0", c, a_if.push, a_if.active);
         end
      end
      af_v = 4'b0000;
      drive(); #1;
      tests_run++;
      if (a_if.pop !== 4'b0001) begin tests_failed++; $display("FAIL bp_release_pop: got %b expected 0001", a_if.pop); end
      @(posedge clk); void'(q[0].pop_front()); ptr_m = 0; #1;
      tests_run++;
      if (a_if.push !== 4'b0001 || a_if.data_out !== 12'h0AA) begin
         tests_failed++; $display("FAIL bp_release_push: got %b %h expected 0001 0aa", a_if.push, a_if.data_out);
      end
   endtask

   task automatic test_bad_dest();
      do_reset();
      b_if.data_in[11:0] = 12'hF12;
      b_if.fifo_empty    = 4'b1110;
      #1;
      tests_run++;
      if (b_if.pop !== 4'b0001) begin tests_failed++; $display("FAIL bad_dest_pop: got %b expected 0001", b_if.pop); end
      @(posedge clk); #1;
      b_if.fifo_empty = 4'b1111;
      tests_run++;
      if (b_if.push !== 3'b000 || b_if.err_dest !== 1'b1 || b_if.data_out !== 12'h000 || b_if.active !== 1'b1) begin
         tests_failed++;
         $display("FAIL bad_dest_out: got push=%b err=%b data=%h active=%b expected 000 1 000 1",
                  b_if.push, b_if.err_dest, b_if.data_out, b_if.active);
      end
      @(posedge clk); #1;
      tests_run++;
      if (b_if.err_dest !== 1'b0 || b_if.active !== 1'b0) begin
         tests_failed++; $display("FAIL bad_dest_pulse: got err=%b active=%b expected 0 0", b_if.err_dest, b_if.active);
      end
      b_if.data_in[23:12]    = 12'h6C3;
      b_if.fifo_empty        = 4'b1101;
      b_if.fifos_almost_full = 3'b100;
      #1;
      tests_run++;
      if (b_if.pop !== 4'b0000) begin tests_failed++; $display("FAIL b_blocked_pop: got %b expected 0000", b_if.pop); end
      b_if.fifos_almost_full = 3'b000;
      #1;
      tests_run++;
      if (b_if.pop !== 4'b0010) begin tests_failed++; $display("FAIL b_dest2_pop: got %b expected 0010", b_if.pop); end
      @(posedge clk); #1;
      b_if.fifo_empty = 4'b1111;
      tests_run++;
      if (b_if.push !== 3'b100 || b_if.data_out !== 12'h6C3 || b_if.err_dest !== 1'b0) begin
         tests_failed++; $display("FAIL b_dest2_push: got %b %h err=%b expected 100 6c3 0", b_if.push, b_if.data_out, b_if.err_dest);
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] w;
      int          g;
      do_reset();
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < 4; i++) q[i].push_back({2'(i), 2'b10, 8'($urandom_range(0, 255))});
      drive(); #1;
      g = ref_grant();
      w = (g >= 0) ? q[g][0] : 12'h000;
      @(posedge clk);
      if (g >= 0) begin void'(q[g].pop_front()); ptr_m = g; end
      #1;
      tests_run++;
      if (a_if.push !== 4'b0100 || a_if.data_out !== w) begin
         tests_failed++; $display("FAIL ar_before: got %b %h expected 0100 %h", a_if.push, a_if.data_out, w);
      end
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (a_if.push !== 4'b0000 || a_if.data_out !== 12'h000 || a_if.active !== 1'b0 || a_if.pop !== 4'b0000) begin
         tests_failed++;
         $display("FAIL ar_immediate: got push=%b data=%h active=%b pop=%b expected 0000 000 0 0000",
                  a_if.push, a_if.data_out, a_if.active, a_if.pop);
      end
      #2 reset = 1'b1;
      ptr_m = 3;
      #1 drive(); #1;
      tests_run++;
      if (a_if.pop !== 4'b0001) begin tests_failed++; $display("FAIL ar_restart_pop: got %b expected 0001", a_if.pop); end
      w = q[0][0];
      @(posedge clk); void'(q[0].pop_front()); ptr_m = 0; #1;
      tests_run++;
      if (a_if.push !== 4'b0100 || a_if.data_out !== w) begin
         tests_failed++; $display("FAIL ar_restart_push: got %b %h expected 0100 %h", a_if.push, a_if.data_out, w);
      end
   endtask

   task automatic test_random();
      logic [3:0]  exp_pop, exp_push;
      logic [11:0] w;
      int          g;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            if (q[i].size() < 3 && $urandom_range(0, 2) != 0)
               q[i].push_back({2'(i), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))});
         af_v = 4'($urandom) & 4'($urandom);
         if ($urandom_range(0, 7) == 0) mode_v = ~mode_v;
         drive(); #1;
         g       = ref_grant();
         exp_pop = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         w       = (g >= 0) ? q[g][0] : 12'h000;
         tests_run++;
         if (a_if.pop !== exp_pop) begin
            tests_failed++; $display("FAIL rand_pop cycle %0d mode %0d: got %b expected %b", c, mode_v, a_if.pop, exp_pop);
         end
         @(posedge clk);
         if (g >= 0) begin void'(q[g].pop_front()); ptr_m = g; end
         #1;
         exp_push = (g >= 0) ? (4'b0001 << w[9:8]) : 4'b0000;
         tests_run++;
         if (a_if.push !== exp_push || a_if.data_out !== w || a_if.active !== (g >= 0) || a_if.err_dest !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_out cycle %0d: got push=%b data=%h active=%b err=%b expected %b %h %b 0",
                     c, a_if.push, a_if.data_out, a_if.active, a_if.err_dest, exp_push, w, (g >= 0));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      test_reset();
      test_round_robin();
      test_strict();
      test_backpressure();
      test_bad_dest();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
